telemetry_frame_tx: RTL and testbench

Downstream formatter between the sensor/encoder registers and the async_transmitter UART TX. It snapshots enc1/enc2 positions, temperature and bill count, then emits one ASCII-hex text frame per period, one byte at a time. Each byte is sent through the transmitter's start/busy handshake. It replaces free-running slot timing with a handshake-driven sequencer that cannot overrun the transmitter.

---
 rtl/telemetry_frame_tx.sv | 158 +++++++++++++++
 tb/tb_telemetry_frame_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/telemetry_frame_tx.sv
// Telemetry frame formatter: snapshots sensor registers and streams a 15-byte
// ASCII-hex frame to a UART transmitter through its start/busy handshake.
module telemetry_frame_tx #(
  parameter int unsigned FRAME_PERIOD   = 32768,
  parameter bit          ONLY_ON_CHANGE = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] enc1_pos,
  input  logic [11:0] enc2_pos,
  input  logic [7:0]  temperature,
  input  logic [7:0]  bill_count,
  input  logic        force_send,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        frame_active,
  output logic [15:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SNAP,
    S_LOAD,
    S_START,
    S_GUARD,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [23:0] CNT_LAST = 24'(FRAME_PERIOD - 1);
  localparam logic [3:0]  IDX_LAST = 4'd14;

  state_t      state_q, state_d;
  logic [23:0] cnt_q, cnt_d;
  logic        pending_q, pending_d;
  logic [39:0] snap_q, snap_d;
  logic [39:0] last_q, last_d;
  logic [3:0]  idx_q, idx_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        frame_active_q, frame_active_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic [39:0] live;
  logic        tick;
  logic        req;
  logic [7:0]  cur_byte;

  assign live = {enc1_pos, enc2_pos, temperature, bill_count};

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Snapshot layout: [39:28] enc1, [27:16] enc2, [15:8] temperature, [7:0] bill.
  always_comb begin
    cur_byte = 8'h20;
    case (idx_q)
      4'd0:    cur_byte = hex_char(snap_q[39:36]);
      4'd1:    cur_byte = hex_char(snap_q[35:32]);
      4'd2:    cur_byte = hex_char(snap_q[31:28]);
      4'd4:    cur_byte = hex_char(snap_q[27:24]);
      4'd5:    cur_byte = hex_char(snap_q[23:20]);
      4'd6:    cur_byte = hex_char(snap_q[19:16]);
      4'd8:    cur_byte = hex_char(snap_q[15:12]);
      4'd9:    cur_byte = hex_char(snap_q[11:8]);
      4'd11:   cur_byte = hex_char(snap_q[7:4]);
      4'd12:   cur_byte = hex_char(snap_q[3:0]);
      4'd13:   cur_byte = 8'h0D;
      4'd14:   cur_byte = 8'h0A;
      default: cur_byte = 8'h20;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q + 24'd1;
    pending_d      = pending_q;
    snap_d         = snap_q;
    last_d         = last_q;
    idx_d          = idx_q;
    tx_data_d      = tx_data_q;
    frame_active_d = frame_active_q;
    frame_count_d  = frame_count_q;
    tx_start       = 1'b0;

    tick = (cnt_q == CNT_LAST);
    if (tick) cnt_d = '0;

    req = force_send | (tick & (!ONLY_ON_CHANGE || (live != last_q)));
    // A request landing on the IDLE->SNAP cycle stays queued for the next frame.
    if (state_q == S_IDLE && pending_q) pending_d = req;
    else                                pending_d = pending_q | req;

    case (state_q)
      S_IDLE: if (pending_q) state_d = S_SNAP;
      S_SNAP: begin
        snap_d         = live;
        last_d         = live;
        idx_d          = '0;
        frame_active_d = 1'b1;
        state_d        = S_LOAD;
      end
      S_LOAD: begin
        tx_data_d = cur_byte;
        state_d   = S_START;
      end
      S_START: if (!tx_busy) begin
        tx_start = 1'b1;
        state_d  = S_GUARD;
      end
      S_GUARD: state_d = S_WAIT;
      S_WAIT: if (!tx_busy) begin
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        frame_count_d  = frame_count_q + 16'd1;
        frame_active_d = 1'b0;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      pending_q      <= 1'b0;
      snap_q         <= '0;
      last_q         <= '0;
      idx_q          <= '0;
      tx_data_q      <= '0;
      frame_active_q <= 1'b0;
      frame_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pending_q      <= pending_d;
      snap_q         <= snap_d;
      last_q         <= last_d;
      idx_q          <= idx_d;
      tx_data_q      <= tx_data_d;
      frame_active_q <= frame_active_d;
      frame_count_q  <= frame_count_d;
    end
  end

  assign tx_data      = tx_data_q;
  assign frame_active = frame_active_q;
  assign frame_count  = frame_count_q;

endmodule

// File: tb/tb_telemetry_frame_tx.sv
// Scoreboard bench for telemetry_frame_tx: two instances (free-running and
// change-only), each with a busy-10-cycles transmitter model and byte monitor.
module tb_telemetry_frame_tx;

  localparam logic [119:0] FA = 120'h413346203031322031392030370D0A;
  localparam logic [119:0] FB = 120'h313233203031322031392030370D0A;
  localparam logic [119:0] FP = 120'h353535203041412031392034320D0A;
  localparam logic [119:0] FQ = 120'h353535203041412031412034320D0A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Instance 0: always-send, long period
  logic        rst0 = 1'b1, force0 = 1'b0, hold0 = 1'b0;
  logic [11:0] e1_0 = 12'hA3F, e2_0 = 12'h012;
  logic [7:0]  t0 = 8'h19, b0 = 8'h07;
  logic        tx_busy0, tx_start0, fa0;
  logic [7:0]  tx_data0;
  logic [15:0] fc0;
  int          bcnt0 = 0;
  logic [7:0]  q0[$];

  // Instance 1: change-only, short period
  logic        rst1 = 1'b1, force1 = 1'b0;
  logic [11:0] e1_1 = 12'h555, e2_1 = 12'h0AA;
  logic [7:0]  t1 = 8'h19, b1 = 8'h42;
  logic        tx_busy1, tx_start1, fa1;
  logic [7:0]  tx_data1;
  logic [15:0] fc1;
  int          bcnt1 = 0;
  logic [7:0]  q1[$];

  telemetry_frame_tx #(.FRAME_PERIOD(50000), .ONLY_ON_CHANGE(1'b0)) dut0 (
    .clk(clk), .rst(rst0), .enc1_pos(e1_0), .enc2_pos(e2_0), .temperature(t0),
    .bill_count(b0), .force_send(force0), .tx_busy(tx_busy0), .tx_start(tx_start0),
    .tx_data(tx_data0), .frame_active(fa0), .frame_count(fc0));

  telemetry_frame_tx #(.FRAME_PERIOD(200), .ONLY_ON_CHANGE(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .enc1_pos(e1_1), .enc2_pos(e2_1), .temperature(t1),
    .bill_count(b1), .force_send(force1), .tx_busy(tx_busy1), .tx_start(tx_start1),
    .tx_data(tx_data1), .frame_active(fa1), .frame_count(fc1));

  // Transmitter models: busy asserts the cycle after start and lasts 10 cycles.
  assign tx_busy0 = (bcnt0 != 0) | hold0;
  assign tx_busy1 = (bcnt1 != 0);
  always @(posedge clk) begin
    if (tx_start0) bcnt0 <= 10; else if (bcnt0 != 0) bcnt0 <= bcnt0 - 1;
    if (tx_start1) bcnt1 <= 10; else if (bcnt1 != 0) bcnt1 <= bcnt1 - 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitors
  always @(negedge clk) begin
    if (tx_start0) begin
      check("fa0_during_byte", {31'd0, fa0}, 32'd1);
      if (q0.size() == 0) check("unexpected_byte0", {24'd0, tx_data0}, 32'hFFFF);
      else check("byte0", {24'd0, tx_data0}, {24'd0, q0.pop_front()});
    end
    if (tx_start1) begin
      if (q1.size() == 0) check("unexpected_byte1", {24'd0, tx_data1}, 32'hFFFF);
      else check("byte1", {24'd0, tx_data1}, {24'd0, q1.pop_front()});
    end
  end

  task automatic push0(input logic [119:0] f);
    for (int i = 0; i < 15; i++) q0.push_back(f[119-8*i -: 8]);
  endtask
  task automatic push1(input logic [119:0] f);
    for (int i = 0; i < 15; i++) q1.push_back(f[119-8*i -: 8]);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse0();
    @(posedge clk); #1 force0 = 1'b1;
    @(posedge clk); #1 force0 = 1'b0;
  endtask

  task automatic wait_fc0(input logic [15:0] n);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (fc0 == n) break;
    end
    check("wait_fc0", {16'd0, fc0}, {16'd0, n});
  endtask

  task automatic wait_fc1(input logic [15:0] n);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (fc1 == n) break;
    end
    check("wait_fc1", {16'd0, fc1}, {16'd0, n});
  endtask

  task automatic wait_starts0(input int n);
    int k = 0;
    for (int i = 0; i < 3000 && k < n; i++) begin
      @(negedge clk);
      if (tx_start0) k++;
    end
    check("wait_starts0", k, n);
  endtask

  initial begin
    int base;
    int gap;

    // Reset state
    cyc(3);
    check("rst_tx_start", {31'd0, tx_start0}, 0);
    check("rst_tx_data", {24'd0, tx_data0}, 0);
    check("rst_frame_active", {31'd0, fa0}, 0);
    check("rst_frame_count", {16'd0, fc0}, 0);
    rst0 = 1'b0;
    cyc(5);
    check("idle_no_frame", {31'd0, fa0}, 0);

    // Basic frame
    base = 0;
    push0(FA);
    pulse0();
    wait_fc0(16'd1);
    check("fa_low_after_frame", {31'd0, fa0}, 0);
    check("q0_empty_f1", q0.size(), 0);

    // Snapshot isolation: enc1 changes mid-frame
    push0(FA);
    pulse0();
    wait_starts0(4);
    @(posedge clk); #1 e1_0 = 12'h123;
    wait_fc0(16'd2);
    push0(FB);
    pulse0();
    wait_fc0(16'd3);
    check("q0_empty_f3", q0.size(), 0);

    // Transmitter stuck busy before the first byte
    @(posedge clk); #1 hold0 = 1'b1;
    base = q0.size();
    push0(FB);
    pulse0();
    cyc(30);
    check("stall_no_start", q0.size(), base + 15);
    check("stall_frame_active", {31'd0, fa0}, 1);
    @(posedge clk); #1 hold0 = 1'b0;
    @(negedge clk);
    check("release_start", {31'd0, tx_start0}, 1);
    wait_fc0(16'd4);

    // Back-to-back: two force_send pulses during a frame queue one frame
    rst0 = 1'b1; cyc(2); rst0 = 1'b0;
    check("fc_after_reset", {16'd0, fc0}, 0);
    push0(FB);
    pulse0();
    wait_starts0(3);
    pulse0();
    cyc(5);
    pulse0();
    push0(FB);
    wait_fc0(16'd1);
    gap = 0;
    while (fa0 == 1'b0 && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    check("idle_gap_cycles", gap, 2);
    wait_fc0(16'd2);
    cyc(300);
    check("no_third_frame", {16'd0, fc0}, 2);
    check("q0_empty_b2b", q0.size(), 0);

    // Asynchronous reset during byte index 5
    push0(FB);
    pulse0();
    wait_starts0(6);
    #1 rst0 = 1'b1;
    #1;
    check("async_rst_tx_start", {31'd0, tx_start0}, 0);
    check("async_rst_frame_active", {31'd0, fa0}, 0);
    check("async_rst_frame_count", {16'd0, fc0}, 0);
    q0.delete();
    @(posedge clk); #1 rst0 = 1'b0;
    push0(FB);
    pulse0();
    cyc(40);
    check("restart_fc_zero", {16'd0, fc0}, 0);
    check("restart_active", {31'd0, fa0}, 1);
    wait_fc0(16'd1);
    check("q0_empty_restart", q0.size(), 0);

    // Change-only mode on instance 1
    push1(FP);
    @(posedge clk); #1 rst1 = 1'b0;
    wait_fc1(16'd1);
    cyc(1000);
    check("static_one_frame", {16'd0, fc1}, 1);
    check("q1_empty_static", q1.size(), 0);
    @(posedge clk); #1 t1 = 8'h1A;
    push1(FQ);
    cyc(2);
    check("change_waits_tick", {16'd0, fc1}, 1);
    wait_fc1(16'd2);
    cyc(450);
    check("change_one_frame", {16'd0, fc1}, 2);
    check("q1_empty_change", q1.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
